// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 divider: fixed 32-step latency, signed/unsigned,
// registered quotient/remainder held until the next completed divide.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              div_start,
  input  logic              div_signed,
  input  logic [DATA_W-1:0] div_x,
  input  logic [DATA_W-1:0] div_y,
  input  logic              flush,
  output logic              div_busy,
  output logic              div_done,
  output logic [DATA_W-1:0] div_result,
  output logic [DATA_W-1:0] mod_result
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [DATA_W-1:0] neg_fix(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? ({DATA_W{1'b0}} - v) : v;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  div_result_q, div_result_d;
  logic [DATA_W-1:0]  mod_result_q, mod_result_d;

  logic [DATA_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0]  dvd_q, dvd_d;
  logic [DATA_W-1:0]  ymag_q, ymag_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;

  // One restoring step: the 33-bit shifted remainder keeps the trial subtract exact
  logic [DATA_W:0]    shifted;
  logic [DATA_W:0]    diff;
  logic               qbit;
  logic [DATA_W-1:0]  rem_nx;
  logic [DATA_W-1:0]  dvd_nx;

  assign shifted = {rem_q, dvd_q[DATA_W-1]};
  assign diff    = shifted - {1'b0, ymag_q};
  assign qbit    = ~diff[DATA_W];
  assign rem_nx  = qbit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
  assign dvd_nx  = {dvd_q[DATA_W-2:0], qbit};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_result_d = div_result_q;
    mod_result_d = mod_result_q;
    rem_d        = rem_q;
    dvd_d        = dvd_q;
    ymag_d       = ymag_q;
    q_neg_d      = q_neg_q;
    r_neg_d      = r_neg_q;
    case (state_q)
      IDLE: begin
        if (div_start && !flush) begin
          state_d = CALC;
          cnt_d   = '0;
          rem_d   = '0;
          dvd_d   = div_signed ? abs_val(div_x) : div_x;
          ymag_d  = div_signed ? abs_val(div_y) : div_y;
          // A zero divisor skips quotient negation; remainder fixup then restores div_x
          q_neg_d = div_signed & (div_x[DATA_W-1] ^ div_y[DATA_W-1]) & (|div_y);
          r_neg_d = div_signed & div_x[DATA_W-1];
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_nx;
          dvd_d = dvd_nx;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            state_d      = DONE;
            div_result_d = neg_fix(dvd_nx, q_neg_q);
            mod_result_d = neg_fix(rem_nx, r_neg_q);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      div_result_q <= '0;
      mod_result_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      div_result_q <= div_result_d;
      mod_result_q <= mod_result_d;
    end
  end

  always_ff @(posedge clk) begin
    rem_q   <= rem_d;
    dvd_q   <= dvd_d;
    ymag_q  <= ymag_d;
    q_neg_q <= q_neg_d;
    r_neg_q <= r_neg_d;
  end

  assign div_busy   = busy_q;
  assign div_done   = done_q;
  assign div_result = div_result_q;
  assign mod_result = mod_result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: expected quotient/remainder pairs are queued at
// start and popped when div_done is seen.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        div_start = 1'b0;
  logic        div_signed = 1'b0;
  logic [31:0] div_x = '0;
  logic [31:0] div_y = '0;
  logic        flush = 1'b0;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_result;
  logic [31:0] mod_result;

  div_unit dut (
    .clk       (clk),
    .reset     (reset),
    .div_start (div_start),
    .div_signed(div_signed),
    .div_x     (div_x),
    .div_y     (div_y),
    .flush     (flush),
    .div_busy  (div_busy),
    .div_done  (div_done),
    .div_result(div_result),
    .mod_result(mod_result)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;
  logic [63:0] sb[$];
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  always @(negedge clk) if (div_done) done_pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    int signed sx;
    int signed sy;
    sx = x;
    sy = y;
    if (y == 32'h0) return {32'hFFFF_FFFF, x};
    if (!sgn) return {x / y, x % y};
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    return {32'(sx / sy), 32'(sx % sy)};
  endfunction

  // Called at a negedge; returns one negedge after the done pulse.
  task automatic run_op(input string tag, input logic sgn, input logic [31:0] x,
                        input logic [31:0] y, input bit glitch);
    logic [63:0] e;
    int k;
    bit seen;
    div_start  = 1'b1;
    div_signed = sgn;
    div_x      = x;
    div_y      = y;
    sb.push_back(model(sgn, x, y));
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      div_start = glitch && (k == 5);
      if (glitch && k == 5) begin
        div_x      = 32'h0000_DEAD;
        div_y      = 32'h1;
        div_signed = ~sgn;
      end
      if (k == 1) chk({tag, " busy"}, {31'b0, div_busy}, 32'h1);
      seen = div_done;
    end
    chk({tag, " latency"}, k, 33);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (seen) begin
        chk({tag, " quotient"}, div_result, e[63:32]);
        chk({tag, " remainder"}, mod_result, e[31:0]);
      end
      last_q = e[63:32];
      last_r = e[31:0];
    end
    @(negedge clk);
    chk({tag, " done pulse width"}, {31'b0, div_done}, 32'h0);
  endtask

  initial begin
    int p0;
    #12;
    chk("reset busy", {31'b0, div_busy}, 32'h0);
    chk("reset done", {31'b0, div_done}, 32'h0);
    chk("reset div_result", div_result, 32'h0);
    chk("reset mod_result", mod_result, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    run_op("u100/7", 1'b0, 32'd100, 32'd7, 1'b0);
    run_op("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("s overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("s div0", 1'b1, 32'h1234_5678, 32'h0, 1'b0);
    run_op("s div0 neg", 1'b1, 32'h8000_0001, 32'h0, 1'b0);
    run_op("u div0", 1'b0, 32'hFFFF_FFF0, 32'h0, 1'b0);
    run_op("u big", 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op("s 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] ry;
      ry = (i < 3) ? $urandom : $urandom_range(1, 1000);
      run_op("rand", i[0], $urandom, ry, 1'b0);
    end

    // Flush on the tenth CALC cycle
    div_start  = 1'b1;
    div_signed = 1'b0;
    div_x      = 32'd1000;
    div_y      = 32'd3;
    @(negedge clk);
    div_start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", {31'b0, div_busy}, 32'h0);
    chk("flush div_result held", div_result, last_q);
    chk("flush mod_result held", mod_result, last_r);
    p0 = done_pulses;
    repeat (40) @(negedge clk);
    #1;
    chk("flush no done", done_pulses - p0, 0);
    run_op("after flush", 1'b0, 32'd1000, 32'd3, 1'b0);

    // Flush and start together in IDLE: start dropped
    div_start = 1'b1;
    flush     = 1'b1;
    div_x     = 32'd50;
    div_y     = 32'd5;
    @(negedge clk);
    div_start = 1'b0;
    flush     = 1'b0;
    chk("flush+start busy", {31'b0, div_busy}, 32'h0);
    p0 = done_pulses;
    repeat (36) @(negedge clk);
    #1;
    chk("flush+start no done", done_pulses - p0, 0);
    chk("flush+start result held", div_result, last_q);

    // Back-to-back with an ignored start pulsed mid-CALC
    p0 = done_pulses;
    run_op("b2b first", 1'b1, 32'hFFFF_FF00, 32'd16, 1'b0);
    run_op("b2b second", 1'b0, 32'd123456, 32'd789, 1'b1);
    div_start = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    chk("b2b done count", done_pulses - p0, 2);

    // Asynchronous reset in the middle of CALC
    div_start  = 1'b1;
    div_signed = 1'b0;
    div_x      = 32'd999;
    div_y      = 32'd10;
    @(negedge clk);
    div_start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async reset busy", {31'b0, div_busy}, 32'h0);
    chk("async reset done", {31'b0, div_done}, 32'h0);
    chk("async reset div_result", div_result, 32'h0);
    chk("async reset mod_result", mod_result, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    run_op("after reset", 1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0);

    chk("scoreboard empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port div_start, input, 1 bit: request from the execute stage to start a divide; sampled only in IDLE.
REQ-004 SHALL have port div_signed, input, 1 bit: 1 = signed divide, 0 = unsigned; sampled with div_start.
REQ-005 SHALL have port div_x, input, 32 bits: dividend; sampled with div_start.
REQ-006 SHALL have port div_y, input, 32 bits: divisor; sampled with div_start.
REQ-007 SHALL have port flush, input, 1 bit: pipeline cancel (exception, ertn, refetch or idle flush).
REQ-008 SHALL have port div_busy, output, 1 bit: high in CALC and DONE.
REQ-009 SHALL have port div_done, output, 1 bit: one-cycle pulse, high only in DONE.
REQ-010 SHALL have port div_result, output, 32 bits: registered quotient, consumed by the memory stage.
REQ-011 SHALL have port mod_result, output, 32 bits: registered remainder, consumed by the memory stage.

Function
REQ-012 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-013 IDLE with div_start=1 and flush=0 SHALL latch the operands and go to CALC.
REQ-014 On that same start, the step counter SHALL be set to 0.
REQ-015 On that same start, operand magnitudes SHALL be latched: absolute value of each operand if div_signed, otherwise the raw value.
REQ-016 On that same start, the result-sign flags SHALL be latched: q_neg = x[31]^y[31], r_neg = x[31], both gated by div_signed.
REQ-017 CALC SHALL perform one restoring radix-2 step per cycle: shift the partial remainder left by 1, bring in the next dividend bit from MSB first, trial-subtract the divisor magnitude, keep the difference if it is non-negative, and shift in the quotient bit.
REQ-018 The partial remainder SHALL be 33 bits wide so that the trial subtraction never overflows.
REQ-019 CALC SHALL run exactly 32 steps; when counter = 31 it SHALL go to DONE and write div_result and mod_result.
REQ-020 The result write SHALL apply sign fixup: quotient negated if q_neg, remainder negated if r_neg (two's complement, 32-bit wrap).
REQ-021 DONE SHALL last one cycle and then return to IDLE.
REQ-022 Latency SHALL be fixed: div_done high exactly 33 cycles after the cycle in which div_start was accepted, independent of operand values.
REQ-023 div_result and mod_result SHALL hold their value from the DONE write until the next DONE write; flush and new starts SHALL NOT change them.
REQ-024 Quotient SHALL truncate toward zero; the remainder SHALL take the sign of the dividend or be zero.
REQ-025 Divide-by-zero (y=0), signed or unsigned, SHALL still take the full latency and give div_result=0xFFFFFFFF and mod_result=div_x; sign fixup SHALL be bypassed.
REQ-026 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL give div_result=0x80000000 and mod_result=0x00000000 with no error indication.
REQ-027 div_start while not in IDLE SHALL be ignored and SHALL NOT disturb the operation in progress.
REQ-028 flush in CALC or DONE SHALL force IDLE at the next edge; div_done SHALL NOT assert for the cancelled operation.
REQ-029 flush and div_start in the same IDLE cycle: flush SHALL win and the start SHALL be dropped.
REQ-030 div_start in the first IDLE cycle after DONE SHALL be accepted (back-to-back operations, no bubble).

Reset
REQ-031 reset SHALL force IDLE immediately and asynchronously, at any time including mid-CALC.
REQ-032 During reset: div_busy=0, div_done=0, div_result=0, mod_result=0, counter=0.
REQ-033 The first div_start after reset deassertion SHALL be accepted normally.

Verification
REQ-034 Unsigned: x=100, y=7, signed=0 -> after 33 cycles div_done pulses for 1 cycle; div_result=14, mod_result=2.
REQ-035 Signed: x=-7 (0xFFFFFFF9), y=2 -> div_result=0xFFFFFFFD (-3), mod_result=0xFFFFFFFF (-1); x=0x80000000, y=-1 -> 0x80000000 / 0.
REQ-036 Divide-by-zero: x=0x12345678, y=0, signed=1 -> after 33 cycles div_result=0xFFFFFFFF, mod_result=0x12345678.
REQ-037 flush on cycle 10 of CALC -> IDLE next cycle, no div_done, outputs keep previous values; next start completes correctly.
REQ-038 reset asserted mid-CALC -> div_busy, div_done and both results read 0 with no clock edge.
REQ-039 Back-to-back: second start the cycle after DONE -> accepted; a start pulsed during CALC is ignored (only 2 done pulses total).
